// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
//
// Parametrised UART transmitter. Accepts a word over a valid/ready handshake
// and serialises it onto an idle-high line as:
//   start(0), DATA_WIDTH data bits, optional parity bit, STOP_BITS stop bits(1)
// Every line bit is held for CLKS_PER_BIT clock cycles. A new word may be
// accepted in the very last cycle of the final stop bit, so back-to-back
// frames leave no idle gap on the line.
//
// Parameters:
//   DATA_WIDTH   payload bits per frame (5..16)
//   CLKS_PER_BIT clock cycles per line bit (>= 1)
//   PARITY_MODE  0 = none, 1 = even, 2 = odd
//   STOP_BITS    1 or 2
//   LSB_FIRST    1 = data[0] first, 0 = data[DATA_WIDTH-1] first
//
// Ports:
//   CLK         rising-edge clock
//   ASYNCRESET  asynchronous, active-high reset
//   valid       producer offers a word
//   data        word to send, sampled only on the accept edge
//   ready       a word can be accepted this cycle
//   O           registered serial line, idle high
//   busy        a frame is in progress
//   done        one-cycle pulse in the final cycle of a frame
// -----------------------------------------------------------------------------
module uart_tx_param #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int LSB_FIRST    = 1
) (
  input  logic                  CLK,
  input  logic                  ASYNCRESET,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ready,
  output logic                  O,
  output logic                  busy,
  output logic                  done
);

  // ---------------------------------------------------------------------------
  // Parameter legality, rejected at elaboration
  // ---------------------------------------------------------------------------
  if (DATA_WIDTH < 5 || DATA_WIDTH > 16) begin : g_bad_data_width
    $error("uart_tx_param: DATA_WIDTH must be in 5..16");
  end
  if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
    $error("uart_tx_param: CLKS_PER_BIT must be >= 1");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity_mode
    $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_WIDTH);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_WIDTH - 1);
  localparam logic             STOP_LAST  = 1'(STOP_BITS - 1);
  localparam bit               HAS_PARITY = (PARITY_MODE != 0);
  localparam bit               ODD_PARITY = (PARITY_MODE == 2);
  localparam bit               SEND_LSB   = (LSB_FIRST != 0);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q,   cnt_d;     // cycles spent in current line bit
  logic [IDX_W-1:0]      idx_q,   idx_d;     // data bit being sent
  logic                  stop_q,  stop_d;    // stop bit being sent
  logic [DATA_WIDTH-1:0] shift_q, shift_d;   // word, shifted out one bit at a time
  logic                  parity_q, parity_d;
  logic                  o_q,     o_d;

  logic bit_end;     // last cycle of the current line bit
  logic last_stop;   // last cycle of the whole frame
  logic accept;

  assign bit_end   = (cnt_q == CNT_LAST);
  assign last_stop = (state_q == STOP) && bit_end && (stop_q == STOP_LAST);

  // The late ready in the final stop cycle is what lets frames abut.
  assign ready  = (state_q == IDLE) || last_stop;
  assign done   = last_stop;
  assign busy   = (state_q != IDLE);
  assign O      = o_q;
  assign accept = valid && ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
    shift_d  = shift_q;
    parity_d = parity_q;

    // The baud counter only runs while a frame is on the line.
    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
      end

      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end

      DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            state_d = HAS_PARITY ? PARITY : STOP;
            stop_d  = 1'b0;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            // Move the next bit to be sent into the output position.
            shift_d = SEND_LSB ? (shift_q >> 1) : (shift_q << 1);
          end
        end
      end

      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          stop_d  = 1'b0;
        end
      end

      STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            state_d = IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // An accept overrides the normal progression; in the final stop cycle this
    // is what turns STOP -> IDLE into STOP -> START.
    if (accept) begin
      state_d  = START;
      cnt_d    = '0;
      idx_d    = '0;
      stop_d   = 1'b0;
      shift_d  = data;
      parity_d = ODD_PARITY ? ~(^data) : (^data);
    end
  end

  // The line value is derived from the *next* state so that O is a plain
  // register yet changes on the same edge as the state it belongs to.
  always_comb begin
    o_d = 1'b1;
    unique case (state_d)
      START:   o_d = 1'b0;
      DATA:    o_d = SEND_LSB ? shift_d[0] : shift_d[DATA_WIDTH-1];
      PARITY:  o_d = parity_d;
      default: o_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      // NOTE: the shift register is a handful of flops, not a memory array, so
      // it is reset with everything else and never holds stale data.
      shift_q  <= '0;
      parity_q <= 1'b0;
      o_q      <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments only in clocked blocks, so every
      // register samples the pre-edge values regardless of statement order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      o_q      <= o_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_param
//
// Five transmitter configurations run side by side on one clock. For each, a
// driver issues words and, whenever the reference model says the word is
// taken, pushes the expected per-cycle line behaviour of the whole frame
// (O, ready, done, busy) into a queue built from the frame format: start bit,
// data bits in the chosen order, parity from the popcount, stop bits, each
// repeated CLKS_PER_BIT times. A monitor pops one entry per cycle (idle values
// when the queue is empty) and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_uart_tx_param;

  typedef struct packed {
    logic o;
    logic ready;
    logic done;
    logic busy;
  } rec_t;

  localparam rec_t IDLE_REC = '{o: 1'b1, ready: 1'b1, done: 1'b0, busy: 1'b0};

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 5; g++) begin : g_cfg
    // cfg0: 8b, 4 clk/bit, no parity, 1 stop, LSB first   (first word 0xA5)
    // cfg1: 8b, 1 clk/bit, even parity, 1 stop, MSB first (first word 0x07)
    // cfg2: 8b, 1 clk/bit, odd parity, 1 stop, MSB first  (first word 0x07)
    // cfg3: 9b, 2 clk/bit, no parity, 2 stop, LSB first   (first word 0x1FF)
    // cfg4: 5b, 3 clk/bit, odd parity, 2 stop, MSB first  (first word 0x16)
    localparam int DW  = (g == 3) ? 9 : (g == 4) ? 5 : 8;
    localparam int CPB = (g == 0) ? 4 : (g == 3) ? 2 : (g == 4) ? 3 : 1;
    localparam int PM  = (g == 1) ? 1 : (g == 2 || g == 4) ? 2 : 0;
    localparam int SB  = (g >= 3) ? 2 : 1;
    localparam int LSB = (g == 1 || g == 2 || g == 4) ? 0 : 1;
    localparam logic [15:0] FIRST = (g == 0) ? 16'h00A5 :
                                    (g == 3) ? 16'h01FF :
                                    (g == 4) ? 16'h0016 : 16'h0007;
    localparam int NBITS = 1 + DW + ((PM != 0) ? 1 : 0) + SB;
    localparam int FRAME = NBITS * CPB;

    logic          rst   = 1'b1;
    logic          valid = 1'b0;
    logic [DW-1:0] data  = '0;
    logic          ready, O, busy, done;

    logic fin         = 1'b0;
    logic model_ready = 1'b1;
    int   n_acc       = 0;
    rec_t exp_q[$];

    uart_tx_param #(
      .DATA_WIDTH  (DW),
      .CLKS_PER_BIT(CPB),
      .PARITY_MODE (PM),
      .STOP_BITS   (SB),
      .LSB_FIRST   (LSB)
    ) dut (
      .CLK       (CLK),
      .ASYNCRESET(rst),
      .valid     (valid),
      .data      (data),
      .ready     (ready),
      .O         (O),
      .busy      (busy),
      .done      (done)
    );

    // Expected line behaviour for one accepted word, one entry per cycle.
    function automatic void push_frame(input logic [DW-1:0] w);
      logic line[$];
      rec_t r;
      line.push_back(1'b0);
      for (int k = 0; k < DW; k++) begin
        line.push_back((LSB != 0) ? w[k] : w[DW-1-k]);
      end
      if (PM != 0) begin
        line.push_back((($countones(w) % 2) == 1) ^ (PM == 2));
      end
      for (int s = 0; s < SB; s++) line.push_back(1'b1);
      for (int i = 0; i < FRAME; i++) begin
        r.o     = line[i / CPB];
        r.busy  = 1'b1;
        r.done  = (i == FRAME - 1);
        r.ready = (i == FRAME - 1);
        exp_q.push_back(r);
      end
    endfunction

    // One clock cycle of stimulus; the model decides whether the word is taken.
    task automatic cycle(input logic v, input logic [DW-1:0] d);
      valid = v;
      data  = d;
      @(posedge CLK);
      if (!rst && v && model_ready) begin
        push_frame(d);
        n_acc++;
      end
      @(negedge CLK);
      #1;
    endtask

    // Monitor: one comparison per cycle against the scoreboard queue.
    initial begin
      rec_t e;
      rec_t a;
      int   cyc;
      cyc = 0;
      forever begin
        @(negedge CLK);
        cyc++;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        else                   e = IDLE_REC;
        a = '{o: O, ready: ready, done: done, busy: busy};
        check($sformatf("cfg%0d cycle%0d {O,ready,done,busy}", g, cyc),
              32'(a), 32'(e));
        model_ready = e.ready;
      end
    end

    // Driver
    initial begin
      int target;

      // valid held high during reset must not be taken
      repeat (3) cycle(1'b1, DW'($urandom));
      rst = 1'b0;

      // single directed frame, then idle
      cycle(1'b1, FIRST[DW-1:0]);
      repeat (FRAME + 3) cycle(1'b0, DW'($urandom));

      // back-to-back: valid held high across two words
      target = n_acc + 2;
      cycle(1'b1, DW'(16'h0001));
      for (int i = 0; i < FRAME + 2 && n_acc < target; i++) begin
        cycle(1'b1, DW'(16'h0080));
      end
      repeat (FRAME + 3) cycle(1'b0, DW'($urandom));

      // random valid, data changing every cycle
      for (int i = 0; i < 400; i++) begin
        cycle($urandom_range(0, 3) != 0, DW'($urandom));
      end
      repeat (FRAME + 3) cycle(1'b0, DW'($urandom));

      // reset during data bit 3 of an all-zero word (line low there)
      cycle(1'b1, '0);
      repeat (4 * CPB) cycle(1'b0, DW'($urandom));
      rst = 1'b1;
      #1;
      check($sformatf("cfg%0d async reset O", g), 32'(O), 32'd1);
      check($sformatf("cfg%0d async reset ready", g), 32'(ready), 32'd1);
      check($sformatf("cfg%0d async reset busy", g), 32'(busy), 32'd0);
      check($sformatf("cfg%0d async reset done", g), 32'(done), 32'd0);
      exp_q.delete();
      repeat (2) cycle(1'b1, DW'($urandom));
      rst = 1'b0;
      cycle(1'b1, DW'(16'h003C));
      repeat (FRAME + 3) cycle(1'b0, DW'($urandom));

      fin = 1'b1;
    end
  end

  initial begin
    int  waited;
    logic all_fin;
    waited  = 0;
    all_fin = 1'b0;
    while (!all_fin && waited < 20000) begin
      @(posedge CLK);
      waited++;
      all_fin = g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin &&
                g_cfg[3].fin && g_cfg[4].fin;
    end
    check("all configurations completed", 32'(all_fin), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
